// File: rtl/arp_req_arb.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// arp_req_arb
//
// Shares the single ARP lookup port (request/response handshake) of the ARP
// block among S_COUNT requesters.
//
// Operation:
//   - A round-robin pick selects one requester and forwards its IP address.
//   - The grant is held until that requester accepts the ARP response.
//   - The response is returned to the granted requester only.
//   - An optional response timeout frees the port when the ARP block stays
//     silent. The late response that may still follow is drained and dropped.
//
// Handshake semantics (all valid/ready pairs):
//   - A transfer happens in a cycle where valid and ready are both high at
//     the rising clock edge.
//   - A source never withdraws valid or changes its payload while waiting for
//     ready. The exception is a requester whose request has not been granted
//     yet: it may drop valid and is then simply not selected.
//
// Parameters:
//   S_COUNT           number of requesters (1..8)
//   RESPONSE_TIMEOUT  cycles to wait for an ARP response after the request
//                     handshake; 0 waits forever
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   s_arp_request_valid/ready  per-requester request handshake
//   s_arp_request_ip           per-requester IP, requester i at [i*32+:32]
//   s_arp_response_valid/ready per-requester response handshake
//   s_arp_response_error/mac   common response registers, fanned out
//   m_arp_request_*            request port towards the ARP block
//   m_arp_response_*           response port from the ARP block
//   busy                       high whenever the FSM is not IDLE
//   grant_index                current or last granted requester
//   dbg_state                  FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)
// -----------------------------------------------------------------------------
module arp_req_arb #(
  parameter int          S_COUNT          = 2,
  parameter int unsigned RESPONSE_TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic [S_COUNT-1:0]     s_arp_request_valid,
  output logic [S_COUNT-1:0]     s_arp_request_ready,
  input  logic [S_COUNT*32-1:0]  s_arp_request_ip,

  output logic [S_COUNT-1:0]     s_arp_response_valid,
  input  logic [S_COUNT-1:0]     s_arp_response_ready,
  output logic [S_COUNT-1:0]     s_arp_response_error,
  output logic [S_COUNT*48-1:0]  s_arp_response_mac,

  output logic                   m_arp_request_valid,
  input  logic                   m_arp_request_ready,
  output logic [31:0]            m_arp_request_ip,

  input  logic                   m_arp_response_valid,
  output logic                   m_arp_response_ready,
  input  logic                   m_arp_response_error,
  input  logic [47:0]            m_arp_response_mac,

  output logic                   busy,
  output logic [2:0]             grant_index,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Pointer holds the last served requester. Resetting it to S_COUNT-1 makes
  // requester 0 the first candidate.
  localparam logic [2:0]  PTR_RST  = 3'(S_COUNT - 1);
  localparam logic [3:0]  S_CNT4   = 4'(S_COUNT);
  localparam logic [31:0] TIMEOUT  = 32'(RESPONSE_TIMEOUT);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic [2:0]           r_ptr;
  logic                 r_stale;
  logic [31:0]          r_cnt;
  logic [2:0]           r_grant;
  logic [31:0]          r_ip;
  logic                 r_err;
  logic [47:0]          r_mac;
  logic                 r_m_req_valid;
  logic                 r_m_resp_ready;
  logic [S_COUNT-1:0]   r_s_resp_valid;
  logic                 r_busy;

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  state_t               w_state_next;
  logic [2:0]           w_ptr_next;
  logic                 w_stale_next;
  logic [31:0]          w_cnt_next;
  logic [2:0]           w_grant_next;
  logic [31:0]          w_ip_next;
  logic                 w_err_next;
  logic [47:0]          w_mac_next;
  logic [S_COUNT-1:0]   w_resp_valid_next;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // Request and response-ready vectors are padded to 8 bits. This lets them be
  // indexed with the 3-bit requester index for any S_COUNT.
  logic [7:0]           w_req_valid8;
  logic [7:0]           w_resp_ready8;
  logic [3:0]           w_rr_idx;
  logic [2:0]           w_sel;
  logic                 w_any;
  logic [31:0]          w_sel_ip;
  logic                 w_grant_ok;

  assign w_req_valid8  = 8'(s_arp_request_valid);
  assign w_resp_ready8 = 8'(s_arp_response_ready);

  // Scan candidates from the farthest offset down to ptr+1.
  // The last hit is therefore the nearest requester after the pointer.
  always_comb begin
    w_rr_idx = '0;
    w_sel    = '0;
    w_any    = 1'b0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      w_rr_idx = {1'b0, r_ptr} + 4'd1 + 4'(i);
      if (w_rr_idx >= S_CNT4) begin
        w_rr_idx = w_rr_idx - S_CNT4;
      end
      if (w_req_valid8[w_rr_idx[2:0]]) begin
        w_sel = w_rr_idx[2:0];
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_ip = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (w_sel == 3'(i)) begin
        w_sel_ip = s_arp_request_ip[i*32 +: 32];
      end
    end
  end

  // A grant is only offered from IDLE, and never while a stale response may
  // still arrive. If one were offered then, that late answer would be handed
  // to the wrong requester. Reset also suppresses the combinational ready.
  assign w_grant_ok = (r_state == ST_IDLE) && !r_stale && w_any && !rst;

  always_comb begin
    s_arp_request_ready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      s_arp_request_ready[i] = w_grant_ok && (w_sel == 3'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_stale_next = r_stale;
    w_cnt_next   = r_cnt;
    w_grant_next = r_grant;
    w_ip_next    = r_ip;
    w_err_next   = r_err;
    w_mac_next   = r_mac;

    // Drain: a response showing up while stale is outside WAIT is the late
    // answer to a timed-out lookup. It is accepted and dropped.
    if (r_stale && (r_state != ST_WAIT) && m_arp_response_valid) begin
      w_stale_next = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_grant_ok) begin
          w_grant_next = w_sel;
          w_ip_next    = w_sel_ip;
          w_state_next = ST_REQ;
        end
      end

      ST_REQ: begin
        if (m_arp_request_ready) begin
          w_cnt_next   = '0;
          w_state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (m_arp_response_valid) begin
          w_err_next   = m_arp_response_error;
          w_mac_next   = m_arp_response_mac;
          w_state_next = ST_RESP;
        end else if (RESPONSE_TIMEOUT != 0) begin
          w_cnt_next = r_cnt + 32'd1;
          if (w_cnt_next == TIMEOUT) begin
            w_err_next   = 1'b1;
            w_mac_next   = '0;
            w_stale_next = 1'b1;
            w_state_next = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (w_resp_ready8[r_grant]) begin
          w_ptr_next   = r_grant;
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_resp_valid_next = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      w_resp_valid_next[i] = (w_state_next == ST_RESP) && (w_grant_next == 3'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ptr          <= PTR_RST;
      r_stale        <= 1'b0;
      r_cnt          <= '0;
      r_grant        <= '0;
      r_ip           <= '0;
      r_err          <= 1'b0;
      r_mac          <= '0;
      r_m_req_valid  <= 1'b0;
      r_m_resp_ready <= 1'b0;
      r_s_resp_valid <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_ptr          <= w_ptr_next;
      r_stale        <= w_stale_next;
      r_cnt          <= w_cnt_next;
      r_grant        <= w_grant_next;
      r_ip           <= w_ip_next;
      r_err          <= w_err_next;
      r_mac          <= w_mac_next;
      // Outputs are decoded from the next state so they line up with it.
      r_m_req_valid  <= (w_state_next == ST_REQ);
      r_m_resp_ready <= (w_state_next == ST_WAIT) || w_stale_next;
      r_s_resp_valid <= w_resp_valid_next;
      r_busy         <= (w_state_next != ST_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_arp_request_valid  = r_m_req_valid;
  assign m_arp_request_ip     = r_ip;
  assign m_arp_response_ready = r_m_resp_ready;
  assign s_arp_response_valid = r_s_resp_valid;
  assign s_arp_response_error = {S_COUNT{r_err}};
  assign s_arp_response_mac   = {S_COUNT{r_mac}};
  assign busy                 = r_busy;
  assign grant_index          = r_grant;
  assign dbg_state            = r_state;

endmodule

// File: tb/tb_arp_req_arb.sv
`timescale 1ns / 1ps
module tb_arp_req_arb;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic [1:0]   s_req_valid;
  logic [1:0]   s_req_ready;
  logic [63:0]  s_req_ip;
  logic [1:0]   s_resp_valid;
  logic [1:0]   s_resp_ready;
  logic [1:0]   s_resp_error;
  logic [95:0]  s_resp_mac;
  logic         m_req_valid;
  logic         m_req_ready;
  logic [31:0]  m_req_ip;
  logic         m_resp_valid;
  logic         m_resp_ready;
  logic         m_resp_error;
  logic [47:0]  m_resp_mac;
  logic         busy;
  logic [2:0]   grant_index;
  logic [1:0]   dbg_state;

  localparam logic [31:0] IP0 = 32'hC0A80102;
  localparam logic [31:0] IP1 = 32'h0A000001;
  localparam logic [47:0] MAC = 48'h5A5152535455;

  arp_req_arb #(
    .S_COUNT          (2),
    .RESPONSE_TIMEOUT (10)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_arp_request_valid  (s_req_valid),
    .s_arp_request_ready  (s_req_ready),
    .s_arp_request_ip     (s_req_ip),
    .s_arp_response_valid (s_resp_valid),
    .s_arp_response_ready (s_resp_ready),
    .s_arp_response_error (s_resp_error),
    .s_arp_response_mac   (s_resp_mac),
    .m_arp_request_valid  (m_req_valid),
    .m_arp_request_ready  (m_req_ready),
    .m_arp_request_ip     (m_req_ip),
    .m_arp_response_valid (m_resp_valid),
    .m_arp_response_ready (m_resp_ready),
    .m_arp_response_error (m_resp_error),
    .m_arp_response_mac   (m_resp_mac),
    .busy                 (busy),
    .grant_index          (grant_index),
    .dbg_state            (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int vec_cnt = 0;
  int err_cnt = 0;

  // Values captured by the lookup driver.
  logic [1:0]  lk_rdy;
  logic [2:0]  lk_gidx;
  logic [31:0] lk_ip;
  logic        lk_mreq;
  logic [1:0]  lk_rv;
  logic [47:0] lk_mac;
  logic        lk_err;

  logic [141:0] all_out;

  // Inputs change at the falling edge. Outputs are sampled 4 ns later,
  // just before the next rising edge.

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_idle();
    s_req_valid  = 2'b00;
    s_req_ip     = {IP1, IP0};
    s_resp_ready = 2'b11;
    m_req_ready  = 1'b1;
    m_resp_valid = 1'b0;
    m_resp_error = 1'b0;
    m_resp_mac   = 48'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sample_all();
    all_out = {s_req_ready, s_resp_valid, s_resp_error, s_resp_mac, m_req_valid,
               m_req_ip, m_resp_ready, busy, grant_index, dbg_state};
  endtask

  // Full lookup from IDLE. The ARP block answers after 'delay' silent WAIT
  // cycles. The driver returns with the response cycle done (ready held high).
  task automatic lookup(input logic [1:0] vmask, input int delay,
                        input logic [47:0] mac, input logic err);
    @(negedge clk);
    s_req_valid = vmask;
    #4;
    lk_rdy = s_req_ready;
    @(negedge clk);
    s_req_valid = 2'b00;
    #4;
    lk_gidx = grant_index;
    lk_ip   = m_req_ip;
    lk_mreq = m_req_valid;
    repeat (delay) @(negedge clk);
    @(negedge clk);
    m_resp_valid = 1'b1;
    m_resp_mac   = mac;
    m_resp_error = err;
    @(negedge clk);
    m_resp_valid = 1'b0;
    m_resp_mac   = 48'h0;
    m_resp_error = 1'b0;
    #4;
    lk_rv  = s_resp_valid;
    lk_mac = s_resp_mac[int'(lk_gidx[0])*48 +: 48];
    lk_err = s_resp_error[lk_gidx[0]];
  endtask

  // Completes a transaction whose grant cycle has just been checked.
  task automatic finish_txn();
    s_resp_ready = 2'b11;
    @(negedge clk);
    s_req_valid = 2'b00;
    @(negedge clk);
    m_resp_valid = 1'b1;
    m_resp_mac   = 48'h00000000ABCD;
    @(negedge clk);
    m_resp_valid = 1'b0;
    m_resp_mac   = 48'h0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #4;
    sample_all();
    vec_cnt++;
    if (all_out !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
  endtask

  task automatic test_single();
    lookup(2'b01, 2, MAC, 1'b0);
    vec_cnt++;
    if (lk_rdy !== 2'b01) begin err_cnt++; $display("FAIL single_req_ready: got %b expected 01", lk_rdy); end
    vec_cnt++;
    if (lk_gidx !== 3'd0) begin err_cnt++; $display("FAIL single_grant: got %0d expected 0", lk_gidx); end
    vec_cnt++;
    if (lk_ip !== IP0) begin err_cnt++; $display("FAIL single_m_ip: got %h expected %h", lk_ip, IP0); end
    vec_cnt++;
    if (lk_mreq !== 1'b1) begin err_cnt++; $display("FAIL single_m_valid: got %b expected 1", lk_mreq); end
    vec_cnt++;
    if (lk_rv !== 2'b01) begin err_cnt++; $display("FAIL single_resp_valid: got %b expected 01", lk_rv); end
    vec_cnt++;
    if (lk_mac !== MAC) begin err_cnt++; $display("FAIL single_mac: got %h expected %h", lk_mac, MAC); end
    vec_cnt++;
    if (lk_err !== 1'b0) begin err_cnt++; $display("FAIL single_err: got %b expected 0", lk_err); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g [4];
    logic [1:0]  exp_oh;
    logic [31:0] exp_ip;
    exp_g = '{3'd0, 3'd1, 3'd0, 3'd1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      exp_oh = (exp_g[i] == 3'd0) ? 2'b01 : 2'b10;
      exp_ip = (exp_g[i] == 3'd0) ? IP0 : IP1;
      lookup(2'b11, 0, 48'h000000001000 + 48'(i), 1'b0);
      vec_cnt++;
      if (lk_rdy !== exp_oh) begin err_cnt++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, lk_rdy, exp_oh); end
      vec_cnt++;
      if (lk_gidx !== exp_g[i]) begin err_cnt++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, lk_gidx, exp_g[i]); end
      vec_cnt++;
      if (lk_ip !== exp_ip) begin err_cnt++; $display("FAIL rr_ip[%0d]: got %h expected %h", i, lk_ip, exp_ip); end
      vec_cnt++;
      if (lk_rv !== exp_oh) begin err_cnt++; $display("FAIL rr_resp_valid[%0d]: got %b expected %b", i, lk_rv, exp_oh); end
    end
  endtask

  task automatic test_hold();
    logic [52:0] obs;
    logic [52:0] exp;
    exp = {2'b10, 48'h112233445566, 2'b00, 1'b1};
    @(negedge clk);
    s_req_valid  = 2'b10;
    s_resp_ready = 2'b00;
    #4;
    vec_cnt++;
    if (s_req_ready !== 2'b10) begin err_cnt++; $display("FAIL hold_grant: got %b expected 10", s_req_ready); end
    @(negedge clk);
    s_req_valid = 2'b00;
    @(negedge clk);
    m_resp_valid = 1'b1;
    m_resp_mac   = 48'h112233445566;
    @(negedge clk);
    m_resp_valid = 1'b0;
    m_resp_mac   = 48'h0;
    s_req_valid  = 2'b01;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #4;
      obs = {s_resp_valid, s_resp_mac[95:48], s_req_ready, busy};
      vec_cnt++;
      if (obs !== exp) begin err_cnt++; $display("FAIL hold_stall[%0d]: got %h expected %h", k, obs, exp); end
    end
    @(negedge clk);
    s_resp_ready = 2'b11;
    #4;
    vec_cnt++;
    if (s_resp_valid !== 2'b10) begin err_cnt++; $display("FAIL hold_accept: got %b expected 10", s_resp_valid); end
    @(negedge clk);
    #4;
    vec_cnt++;
    if ({s_req_ready, busy} !== 3'b010) begin
      err_cnt++; $display("FAIL hold_next_grant: got %b expected 010", {s_req_ready, busy});
    end
    finish_txn();
  endtask

  task automatic test_error();
    lookup(2'b01, 1, MAC, 1'b1);
    vec_cnt++;
    if (lk_rdy !== 2'b01) begin err_cnt++; $display("FAIL err_ready: got %b expected 01", lk_rdy); end
    vec_cnt++;
    if (lk_rv !== 2'b01) begin err_cnt++; $display("FAIL err_resp_valid: got %b expected 01", lk_rv); end
    vec_cnt++;
    if (lk_err !== 1'b1) begin err_cnt++; $display("FAIL err_flag: got %b expected 1", lk_err); end
    vec_cnt++;
    if (lk_mac !== MAC) begin err_cnt++; $display("FAIL err_mac: got %h expected %h", lk_mac, MAC); end
    @(negedge clk);
    #4;
    vec_cnt++;
    if ({m_req_valid, busy, s_resp_valid} !== 4'b0000) begin
      err_cnt++; $display("FAIL err_no_retry: got %b expected 0000", {m_req_valid, busy, s_resp_valid});
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    s_req_valid = 2'b10;
    #4;
    vec_cnt++;
    if (s_req_ready !== 2'b10) begin err_cnt++; $display("FAIL to_grant: got %b expected 10", s_req_ready); end
    @(negedge clk);           // request handshake cycle
    s_req_valid = 2'b00;
    repeat (9) @(negedge clk);
    @(negedge clk);           // 10th cycle after the handshake
    #4;
    vec_cnt++;
    if ({s_resp_valid, m_resp_ready} !== 3'b001) begin
      err_cnt++; $display("FAIL to_early: got %b expected 001", {s_resp_valid, m_resp_ready});
    end
    @(negedge clk);           // 11th cycle after the handshake
    #4;
    vec_cnt++;
    if ({s_resp_valid, s_resp_error[1], s_resp_mac[95:48]} !== {2'b10, 1'b1, 48'h0}) begin
      err_cnt++; $display("FAIL to_resp: got %h expected %h",
                          {s_resp_valid, s_resp_error[1], s_resp_mac[95:48]}, {2'b10, 1'b1, 48'h0});
    end
    @(negedge clk);
    s_req_valid = 2'b11;
    #4;
    vec_cnt++;
    if ({s_req_ready, m_resp_ready, busy} !== 4'b0010) begin
      err_cnt++; $display("FAIL to_blocked: got %b expected 0010", {s_req_ready, m_resp_ready, busy});
    end
    @(negedge clk);
    m_resp_valid = 1'b1;
    m_resp_mac   = 48'hDEADBEEF0001;
    #4;
    vec_cnt++;
    if (s_req_ready !== 2'b00) begin err_cnt++; $display("FAIL to_blocked_late: got %b expected 00", s_req_ready); end
    @(negedge clk);
    m_resp_valid = 1'b0;
    m_resp_mac   = 48'h0;
    #4;
    vec_cnt++;
    if ({s_req_ready, m_resp_ready, s_resp_valid} !== 5'b01000) begin
      err_cnt++; $display("FAIL to_drained: got %b expected 01000", {s_req_ready, m_resp_ready, s_resp_valid});
    end
    finish_txn();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    s_req_valid = 2'b11;
    #4;
    vec_cnt++;
    if (s_req_ready !== 2'b10) begin err_cnt++; $display("FAIL rm_grant: got %b expected 10", s_req_ready); end
    @(negedge clk);           // REQ
    @(negedge clk);           // WAIT
    rst = 1'b1;
    @(negedge clk);
    #4;
    sample_all();
    vec_cnt++;
    if (all_out !== '0) begin err_cnt++; $display("FAIL rm_outputs: got %h expected 0", all_out); end
    @(negedge clk);
    rst = 1'b0;
    #4;
    vec_cnt++;
    if (s_req_ready !== 2'b01) begin err_cnt++; $display("FAIL rm_after: got %b expected 01", s_req_ready); end
    finish_txn();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    drive_idle();
    apply_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_error();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/arp_req_arb.md
Name: arp_req_arb

Overview:
- Shares the single ARP lookup port (request/response handshake) of the ARP block among S_COUNT requesters, e.g. the IP TX path and future ICMP/UDP helpers.
- Selects one requester round-robin and forwards its IP address to the ARP block.
- Holds the grant until that requester has accepted the response, then returns the ARP response to it alone.
- An optional response timeout frees the port if the ARP block never answers; stale late responses are drained.

Parameters:
- S_COUNT, 2, number of requesters (1..8).
- RESPONSE_TIMEOUT, 0, clk cycles to wait for an ARP response after the request handshake; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_arp_request_valid  in  S_COUNT  per-requester request valid
- s_arp_request_ready  out  S_COUNT  per-requester request ready
- s_arp_request_ip  in  S_COUNT*32  per-requester IP; requester i uses bits [i*32+:32]
- s_arp_response_valid  out  S_COUNT  per-requester response valid
- s_arp_response_ready  in  S_COUNT  per-requester response ready
- s_arp_response_error  out  S_COUNT  response error (common register, fanned out)
- s_arp_response_mac  out  S_COUNT*48  response MAC (common register, replicated)
- m_arp_request_valid  out  1  request valid to the ARP block
- m_arp_request_ready  in  1  request ready from the ARP block
- m_arp_request_ip  out  32  latched IP of the granted requester
- m_arp_response_valid  in  1  response valid from the ARP block
- m_arp_response_ready  out  1  response ready to the ARP block
- m_arp_response_error  in  1  response error from the ARP block
- m_arp_response_mac  in  48  response MAC from the ARP block
- busy  out  1  high in any state other than IDLE
- grant_index  out  3  index of the current or last granted requester

Behaviour:
- Reset:
  - State goes to IDLE.
  - Round-robin pointer is set so requester 0 has highest priority.
  - stale and the timeout counter are cleared.
  - All valid/ready outputs, m_arp_request_ip, the response registers, busy and grant_index reset to 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If stale=0 and any s_arp_request_valid is high, select the first set bit at or after index ptr+1 (mod S_COUNT).
  - Assert s_arp_request_ready[g] combinationally in that same cycle.
  - Latch the IP into m_arp_request_ip and g into grant_index, then go to REQ.
  - All s_arp_request_ready bits are 0 whenever stale=1 or the state is not IDLE.
- REQ:
  - m_arp_request_valid=1; the IP is held stable.
  - On m_arp_request_ready, clear the timeout counter and go to WAIT.
- WAIT:
  - m_arp_response_ready=1.
  - On m_arp_response_valid, latch error and mac, then go to RESP.
  - Otherwise, if RESPONSE_TIMEOUT!=0, increment the counter. When it equals RESPONSE_TIMEOUT, latch error=1 and mac=0, set stale=1, and go to RESP.
- RESP:
  - s_arp_response_valid[g]=1; all other bits are 0.
  - On s_arp_response_ready[g], set ptr=g and go to IDLE.
- Minimum latency:
  - Request accept to m_arp_request_valid: 1 cycle.
  - m_arp_response_valid to s_arp_response_valid: 1 cycle.
  - Back-to-back grants: next request is accepted in the cycle after RESP completes.
- Stale drain:
  - While stale=1 outside WAIT, m_arp_response_ready=1.
  - An m_arp_response_valid in that case is discarded and clears stale.
  - No new request is granted while stale=1, so no response is ever misattributed.
  - In any other state with stale=0, m_arp_response_ready=0.
- A requester dropping valid before grant is legal: it is simply not selected.
- Ports with S_COUNT=1 degenerate to a pass-through with a single-cycle register stage.
- Reset mid-transaction:
  - All state is dropped and the ARP block is assumed reset by the same rst.
  - No response is delivered to the previously granted requester.
- Timer width: 32 bits. RESPONSE_TIMEOUT must be below 2^32.

Test Plan:
- Single requester 0, ip=0xC0A80102; ARP block answers 3 cycles later with mac=0x5A5152535455, error=0:
  - m_arp_request_ip=0xC0A80102.
  - s_arp_response_valid=2'b01 with that mac, 1 cycle after the response.
- Both requesters valid together from reset:
  - Grant order is 0, 1, 0, 1 over 4 consecutive lookups; grant_index follows.
  - The response never appears on the ungranted bit.
- Requester 1 holds s_arp_response_ready=0 for 5 cycles:
  - The response stays valid and stable.
  - s_arp_request_ready[0] stays 0 throughout.
  - Busy=1 until the handshake completes.
- ARP block returns error=1:
  - The granted requester sees s_arp_response_error=1 and mac=0x5A5152535455 unchanged from input.
  - No retry is issued.
- RESPONSE_TIMEOUT=10, ARP silent:
  - Error=1, mac=0 to the requester 11 cycles after the request handshake.
  - A new request is blocked until the late ARP response arrives; that response is discarded and the next grant proceeds.
- rst asserted in WAIT:
  - The next cycle shows all outputs 0 and state IDLE.
  - After rst releases, requester 0 wins against requester 1.
